// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider, 2W-bit dividend by W-bit divisor
// One quotient bit per clock; zero divisor and quotient overflow resolve in a single cycle.
module seq_divider #(
    parameter int W = 36
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2*W-1:0] IN1,
    input  logic [W-1:0]   IN2,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [W-1:0]   QUOTIENT,
    output logic [W-1:0]   REMAINDER,
    output logic           DIV_ZERO,
    output logic           OVERFLOW
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W:0]    r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [W:0]    t;
    logic          t_ge;
    logic [W:0]    r_nxt;
    logic [W-1:0]  q_nxt;

    // Partial remainder stays below D, so shifting in the next dividend bit fits in W+1 bits.
    always_comb begin
        t     = {r_q[W-1:0], q_q[W-1]};
        t_ge  = (t >= {1'b0, d_q});
        r_nxt = t_ge ? (t - {1'b0, d_q}) : t;
        q_nxt = {q_q[W-2:0], t_ge};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    if (IN2 == '0) begin
                        dz_d    = 1'b1;
                        ov_d    = 1'b0;
                        quo_d   = '1;
                        rem_d   = IN1[W-1:0];
                        state_d = S_DONE;
                    end else if (IN1[2*W-1:W] >= IN2) begin
                        dz_d    = 1'b0;
                        ov_d    = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        r_d     = {1'b0, IN1[2*W-1:W]};
                        q_d     = IN1[W-1:0];
                        d_d     = IN2;
                        cnt_d   = CW'(W - 1);
                        dz_d    = 1'b0;
                        ov_d    = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d = r_nxt;
                q_d = q_nxt;
                if (cnt_q == '0) begin
                    quo_d   = q_nxt;
                    rem_d   = r_nxt[W-1:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign QUOTIENT  = quo_q;
    assign REMAINDER = rem_q;
    assign DIV_ZERO  = dz_q;
    assign OVERFLOW  = ov_q;

endmodule
